// File: rtl/disp_scheduler.sv
// disp_scheduler: arbitrates one external binary-to-BCD converter between the
// credit register and change-return requests, holds a change message for a
// fixed time, and time-multiplexes the two digits onto a 2-digit common-anode
// display (ones in slot 0, tens in slot 1 with leading-zero blanking).
module disp_scheduler #(
   parameter int SCAN_DIV    = 50000,
   parameter int HOLD_CYCLES = 100000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] credit_in,
   input  logic       change_valid,
   input  logic [4:0] change_in,
   output logic [4:0] bcd_bin,
   input  logic [3:0] bcd_tens,
   input  logic [3:0] bcd_ones,
   output logic [3:0] digit,
   output logic [1:0] anode,
   output logic       src_change,
   output logic       busy,
   output logic       change_ack
);

   localparam int SW = $clog2(SCAN_DIV);
   localparam int HW = $clog2(HOLD_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_CREDIT   = 2'd0,
      ST_CONV_CRD = 2'd1,
      ST_CONV_CHG = 2'd2,
      ST_CHANGE   = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [4:0]    bcd_bin_q, bcd_bin_d;
   logic [4:0]    last_credit_q, last_credit_d;
   logic [3:0]    disp_tens_q, disp_tens_d;
   logic [3:0]    disp_ones_q, disp_ones_d;
   logic          src_change_q, src_change_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          pend_q, pend_d;
   logic [4:0]    pend_val_q, pend_val_d;
   logic [SW-1:0] scan_cnt_q, scan_cnt_d;
   logic          scan_sel_q, scan_sel_d;

   // A live request and a request parked during a conversion are treated alike;
   // the live one carries the newer value, so it wins.
   logic       req;
   logic [4:0] req_val;
   assign req     = change_valid | pend_q;
   assign req_val = change_valid ? change_in : pend_val_q;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_CREDIT;
      else        state_q <= state_d;
   end

   // Next-state logic: change requests take priority over credit updates
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_CREDIT: begin
            if (req)                            state_d = ST_CONV_CHG;
            else if (credit_in != last_credit_q) state_d = ST_CONV_CRD;
         end
         ST_CONV_CRD: state_d = ST_CREDIT;
         ST_CONV_CHG: state_d = ST_CHANGE;
         ST_CHANGE: begin
            if (req)                 state_d = ST_CONV_CHG;
            else if (hold_q == '0)   state_d = ST_CONV_CRD;
         end
         default: state_d = ST_CREDIT;
      endcase
   end

   // FSM outputs: converter in use, and the cycle change digits are captured
   always_comb begin
      busy       = (state_q == ST_CONV_CRD) || (state_q == ST_CONV_CHG);
      change_ack = (state_q == ST_CONV_CHG);
   end

   // Datapath next values: operand load, digit capture, hold timer, pending request
   always_comb begin
      bcd_bin_d     = bcd_bin_q;
      last_credit_d = last_credit_q;
      disp_tens_d   = disp_tens_q;
      disp_ones_d   = disp_ones_q;
      src_change_d  = src_change_q;
      hold_d        = hold_q;
      pend_d        = pend_q;
      pend_val_d    = pend_val_q;
      case (state_q)
         ST_CREDIT: begin
            if (req) begin
               bcd_bin_d = req_val;
               pend_d    = 1'b0;
            end else if (credit_in != last_credit_q) begin
               bcd_bin_d     = credit_in;
               last_credit_d = credit_in;
            end
         end
         ST_CONV_CRD, ST_CONV_CHG: begin
            disp_tens_d  = bcd_tens;
            disp_ones_d  = bcd_ones;
            src_change_d = (state_q == ST_CONV_CHG);
            if (state_q == ST_CONV_CHG) hold_d = HW'(HOLD_CYCLES - 1);
            // Converter is occupied: park the request for the next free cycle
            if (change_valid) begin
               pend_d     = 1'b1;
               pend_val_d = change_in;
            end
         end
         ST_CHANGE: begin
            if (req) begin
               bcd_bin_d = req_val;
               pend_d    = 1'b0;
            end else if (hold_q == '0) begin
               bcd_bin_d     = credit_in;
               last_credit_d = credit_in;
            end else begin
               hold_d = hold_q - HW'(1);
            end
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd_bin_q     <= '0;
         last_credit_q <= '0;
         disp_tens_q   <= '0;
         disp_ones_q   <= '0;
         src_change_q  <= 1'b0;
         hold_q        <= '0;
         pend_q        <= 1'b0;
         pend_val_q    <= '0;
      end else begin
         bcd_bin_q     <= bcd_bin_d;
         last_credit_q <= last_credit_d;
         disp_tens_q   <= disp_tens_d;
         disp_ones_q   <= disp_ones_d;
         src_change_q  <= src_change_d;
         hold_q        <= hold_d;
         pend_q        <= pend_d;
         pend_val_q    <= pend_val_d;
      end
   end

   // Free-running refresh counter; digit slot flips on each wrap
   always_comb begin
      if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
         scan_cnt_d = '0;
         scan_sel_d = ~scan_sel_q;
      end else begin
         scan_cnt_d = scan_cnt_q + SW'(1);
         scan_sel_d = scan_sel_q;
      end
   end

   // Scan registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt_q <= '0;
         scan_sel_q <= 1'b0;
      end else begin
         scan_cnt_q <= scan_cnt_d;
         scan_sel_q <= scan_sel_d;
      end
   end

   // Digit mux and active-low anode drive; a zero tens digit is blanked
   always_comb begin
      if (scan_sel_q) begin
         digit = disp_tens_q;
         anode = (disp_tens_q != 4'd0) ? 2'b01 : 2'b11;
      end else begin
         digit = disp_ones_q;
         anode = 2'b10;
      end
   end

   assign bcd_bin    = bcd_bin_q;
   assign src_change = src_change_q;

endmodule

// File: tb/tb_disp_scheduler.sv
// Bench for disp_scheduler: directed scenarios plus random traffic, compared
// every cycle against a value-level model of the display behaviour.
module tb_disp_scheduler;

   localparam int SCAN_DIV = 4;
   localparam int HOLD     = 10;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] credit_in;
   logic       change_valid;
   logic [4:0] change_in;
   logic [4:0] bcd_bin;
   logic [3:0] bcd_tens;
   logic [3:0] bcd_ones;
   logic [3:0] digit;
   logic [1:0] anode;
   logic       src_change;
   logic       busy;
   logic       change_ack;

   disp_scheduler #(.SCAN_DIV(SCAN_DIV), .HOLD_CYCLES(HOLD)) dut (
      .clk(clk), .rst_n(rst_n), .credit_in(credit_in),
      .change_valid(change_valid), .change_in(change_in),
      .bcd_bin(bcd_bin), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones),
      .digit(digit), .anode(anode), .src_change(src_change),
      .busy(busy), .change_ack(change_ack)
   );

   always #5 clk = ~clk;

   // External combinational converter
   assign bcd_tens = 4'(bcd_bin / 5'd10);
   assign bcd_ones = 4'(bcd_bin % 5'd10);

   int n_pass = 0;
   int n_chk  = 0;

   task automatic check_val(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
   endtask

   // Model: what is being done (0 idle, 1 converting credit, 2 converting
   // change, 3 showing change), which value is shown, and a countdown of the
   // remaining showing cycles.
   int m_bin, m_last, m_shown, m_src, m_phase, m_left, m_pend, m_pval, m_cyc;
   int cur_credit;

   task automatic model_reset();
      m_bin = 0; m_last = 0; m_shown = 0; m_src = 0; m_phase = 0;
      m_left = 0; m_pend = 0; m_pval = 0; m_cyc = 0;
   endtask

   task automatic model_step(input int cv, input int cin, input int crd);
      int req, rv;
      req = (cv != 0) || (m_pend != 0);
      rv  = (cv != 0) ? cin : m_pval;
      case (m_phase)
         0: begin
            if (req != 0) begin m_bin = rv; m_pend = 0; m_phase = 2; end
            else if (crd != m_last) begin m_bin = crd; m_last = crd; m_phase = 1; end
         end
         1, 2: begin
            m_shown = m_bin;
            m_src   = (m_phase == 2) ? 1 : 0;
            if (m_phase == 2) begin m_left = HOLD; m_phase = 3; end
            else m_phase = 0;
            if (cv != 0) begin m_pend = 1; m_pval = cin; end
         end
         default: begin
            if (req != 0) begin m_bin = rv; m_pend = 0; m_phase = 2; end
            else if (m_left == 1) begin m_bin = crd; m_last = crd; m_phase = 1; end
            else m_left--;
         end
      endcase
      m_cyc++;
   endtask

   task automatic check_outputs();
      int sel, tens, ones;
      sel  = (m_cyc / SCAN_DIV) % 2;
      tens = m_shown / 10;
      ones = m_shown % 10;
      check_val("bcd_bin", int'(bcd_bin), m_bin);
      check_val("src_change", int'(src_change), m_src);
      check_val("busy", int'(busy), (m_phase == 1 || m_phase == 2) ? 1 : 0);
      check_val("change_ack", int'(change_ack), (m_phase == 2) ? 1 : 0);
      check_val("digit", int'(digit), (sel != 0) ? tens : ones);
      check_val("anode", int'(anode), (sel != 0) ? ((tens != 0) ? 1 : 3) : 2);
   endtask

   task automatic cycle(input int cv, input int cin);
      change_valid = (cv != 0);
      change_in    = 5'(cin);
      credit_in    = 5'(cur_credit);
      model_step(cv, cin, cur_credit);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0);
   endtask

   initial begin
      rst_n = 1'b0; credit_in = '0; change_valid = 1'b0; change_in = '0;
      cur_credit = 0;
      model_reset();
      repeat (2) @(negedge clk);
      check_outputs();
      rst_n = 1'b1;

      // Idle with zero credit: blanked tens, no conversions
      idle(12);
      // Credit 0 -> 23
      cur_credit = 23; idle(8);
      // Change 17 shown, then revert to credit
      cycle(1, 17); idle(15);
      // Change and credit update in the same cycle
      cur_credit = 5; cycle(1, 17); idle(15);
      // Restart of the hold by a second change
      cycle(1, 17); idle(4); cycle(1, 9); idle(15);
      // Change requested while credit conversion is busy (pending path)
      cur_credit = 31; cycle(0, 0); cycle(1, 12); idle(14);
      // Two back-to-back requests: the later value must win
      cycle(1, 3); cycle(1, 28); idle(15);
      // Asynchronous reset in the middle of a change hold
      cycle(1, 17); idle(3);
      #2 rst_n = 1'b0;
      change_valid = 1'b0;
      model_reset();
      #1 check_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      idle(8);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         int cv, cin;
         cv  = ($urandom_range(0, 9) == 0) ? 1 : 0;
         cin = int'($urandom_range(0, 31));
         if ($urandom_range(0, 7) == 0) cur_credit = int'($urandom_range(0, 31));
         cycle(cv, cin);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
